vx_l1_mem_arb: RTL

VX_L1_MEM_ARB -- requirements
Module: VX_l1_mem_arb

---
 rtl/vx_l1_mem_arb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vx_l1_mem_arb.sv
// L1 memory arbiter: merges NUM_INPUTS cache request streams onto one memory port
// and routes responses back by tag index. Optional perf counters: VX_L1_MEM_ARB_PERF_EN.
module vx_l1_mem_arb #(
    parameter int    NUM_INPUTS  = 2,
    parameter int    ADDR_WIDTH  = 26,
    parameter int    DATA_SIZE   = 64,
    parameter int    TAG_WIDTH   = 8,
    parameter string ARBITER     = "P",
    parameter int    MAX_PENDING = 16,
    localparam int   DW  = 8 * DATA_SIZE,
    localparam int   LN  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int   OTW = TAG_WIDTH + LN
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUTS-1:0]           in_req_valid,
    input  logic [NUM_INPUTS-1:0]           in_req_rw,
    input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] in_req_addr,
    input  logic [NUM_INPUTS*DW-1:0]        in_req_data,
    input  logic [NUM_INPUTS*DATA_SIZE-1:0] in_req_byteen,
    input  logic [NUM_INPUTS*TAG_WIDTH-1:0] in_req_tag,
    output logic [NUM_INPUTS-1:0]           in_req_ready,
    output logic [NUM_INPUTS-1:0]           in_rsp_valid,
    output logic [NUM_INPUTS*DW-1:0]        in_rsp_data,
    output logic [NUM_INPUTS*TAG_WIDTH-1:0] in_rsp_tag,
    input  logic [NUM_INPUTS-1:0]           in_rsp_ready,
    output logic                            out_req_valid,
    output logic                            out_req_rw,
    output logic [ADDR_WIDTH-1:0]           out_req_addr,
    output logic [DW-1:0]                   out_req_data,
    output logic [DATA_SIZE-1:0]            out_req_byteen,
    output logic [OTW-1:0]                  out_req_tag,
    input  logic                            out_req_ready,
    input  logic                            out_rsp_valid,
    input  logic [DW-1:0]                   out_rsp_data,
    input  logic [OTW-1:0]                  out_rsp_tag,
    output logic                            out_rsp_ready,
    output logic                            busy
`ifdef VX_L1_MEM_ARB_PERF_EN
    ,
    output logic [NUM_INPUTS*32-1:0]        perf_stalls
`endif
);

    localparam int EW = 1 + ADDR_WIDTH + DW + DATA_SIZE + OTW;
    localparam bit RR = (ARBITER == "R");

    logic                      rst_d_reg;
    logic                      live;
    logic [LN-1:0]             ptr_reg;
    logic [LN-1:0]             win_idx;
    logic                      win_valid;
    logic [NUM_INPUTS-1:0]     eligible, pend_nz, rd_fire, rsp_fire, rsp_sel;
    logic [NUM_INPUTS-1:0]     hi_mask, hi_req, pick_src, grant;
    logic [NUM_INPUTS:0][LN-1:0] idx_acc;
    logic                      space, accept, pop;
    logic [EW-1:0]             buf_reg [2];
    logic [EW-1:0]             wr_entry;
    logic                      wr_ptr_reg, rd_ptr_reg;
    logic [1:0]                count_reg;
    logic [LN-1:0]             rsp_idx;

    // Outputs stay quiet for the reset cycle and the one following it.
    assign live  = !reset && !rst_d_reg;
    assign space = (count_reg != 2'd2);

    // Round-robin: prefer eligible inputs at or above the pointer, else wrap around.
    assign hi_mask   = RR ? ~((NUM_INPUTS'(1) << ptr_reg) - NUM_INPUTS'(1)) : '1;
    assign hi_req    = eligible & hi_mask;
    assign pick_src  = (hi_req != '0) ? hi_req : eligible;
    assign grant     = pick_src & (~pick_src + NUM_INPUTS'(1));
    assign win_valid = |eligible;
    assign idx_acc[0] = '0;
    assign win_idx   = idx_acc[NUM_INPUTS];

    assign accept       = win_valid && space && live;
    assign in_req_ready = grant & {NUM_INPUTS{space && live}};
    assign rd_fire      = in_req_ready & in_req_valid & ~in_req_rw;

    assign wr_entry = {|(grant & in_req_rw),
                       in_req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH],
                       in_req_data[win_idx*DW +: DW],
                       in_req_byteen[win_idx*DATA_SIZE +: DATA_SIZE],
                       in_req_tag[win_idx*TAG_WIDTH +: TAG_WIDTH],
                       win_idx};

    assign rsp_idx       = out_rsp_tag[LN-1:0];
    assign out_rsp_ready = |(rsp_sel & in_rsp_ready);
    assign rsp_fire      = in_rsp_valid & in_rsp_ready;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
        logic [7:0] pending_reg;

        assign idx_acc[gi+1] = idx_acc[gi] | (grant[gi] ? LN'(gi) : '0);
        assign eligible[gi]  = in_req_valid[gi] && (in_req_rw[gi] || (pending_reg < 8'(MAX_PENDING)));
        assign pend_nz[gi]   = (pending_reg != 8'd0);

        assign rsp_sel[gi]                        = (rsp_idx == LN'(gi));
        assign in_rsp_valid[gi]                   = out_rsp_valid && rsp_sel[gi];
        assign in_rsp_tag[gi*TAG_WIDTH +: TAG_WIDTH] = out_rsp_tag[OTW-1:LN];
        assign in_rsp_data[gi*DW +: DW]           = out_rsp_data;

        // Simultaneous read accept and response cancel out.
        always_ff @(posedge clk) begin
            if (reset)
                pending_reg <= '0;
            else if (rd_fire[gi] && !rsp_fire[gi])
                pending_reg <= pending_reg + 8'd1;
            else if (!rd_fire[gi] && rsp_fire[gi] && pending_reg != 8'd0)
                pending_reg <= pending_reg - 8'd1;
        end

`ifdef VX_L1_MEM_ARB_PERF_EN
        logic [31:0] stall_cnt_reg;
        always_ff @(posedge clk) begin
            if (reset)
                stall_cnt_reg <= '0;
            else if (in_req_valid[gi] && !in_req_ready[gi])
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
        assign perf_stalls[gi*32 +: 32] = stall_cnt_reg;
`endif
    end

    always_ff @(posedge clk) begin
        if (accept)
            buf_reg[wr_ptr_reg] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rst_d_reg  <= 1'b1;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            ptr_reg    <= '0;
        end else begin
            rst_d_reg <= 1'b0;
            if (accept)
                wr_ptr_reg <= !wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= !rd_ptr_reg;
            count_reg <= count_reg + {1'b0, accept} - {1'b0, pop};
            if (RR && accept)
                ptr_reg <= (32'(win_idx) == NUM_INPUTS - 1) ? '0 : win_idx + 1'b1;
        end
    end

    assign out_req_valid = live && (count_reg != 2'd0);
    assign pop           = out_req_valid && out_req_ready;
    assign {out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag} = buf_reg[rd_ptr_reg];

    assign busy = live && ((|pend_nz) || (count_reg != 2'd0));

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && out_rsp_valid) begin
            assert (|rsp_sel);
            assert (|(rsp_sel & pend_nz));
        end
    end
`endif

endmodule
